// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pin bus between NREQ requesters.
// Each grant is a bounded single-direction burst; write-to-read changes get turnaround idle cycles.
module uio_bus_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned TURN     = 1,
    parameter int unsigned MAXBURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [8*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned BW = 4;
    localparam int unsigned TW = $clog2(TURN + 2);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [7:0]      rdata_n, uio_out_n, uio_oe_n;
    logic            rvalid_n, busy_n;
    logic [PW-1:0]   ptr, ptr_n, owner, owner_n, win;
    logic            last_write, last_write_n, bdir, bdir_n, found;
    logic [BW-1:0]   beat, beat_n;
    logic [TW-1:0]   turn_cnt, turn_n;
    int              idx;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Next-state and output decode
    always_comb begin
        state_n      = state;
        gnt_n        = gnt;
        rdata_n      = rdata;
        rvalid_n     = 1'b0;
        uio_out_n    = uio_out;
        uio_oe_n     = uio_oe;
        ptr_n        = ptr;
        last_write_n = last_write;
        beat_n       = beat;
        owner_n      = owner;
        bdir_n       = bdir;
        turn_n       = turn_cnt;
        found        = 1'b0;
        win          = '0;
        idx          = 0;

        // First requester at or above ptr, wrapping
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = (int'(ptr) + i) % int'(NREQ);
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        if (!ena) begin
            state_n      = S_IDLE;
            gnt_n        = '0;
            uio_oe_n     = 8'h00;
            last_write_n = 1'b0;
            beat_n       = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner_n = win;
                        bdir_n  = dir[win];
                        beat_n  = '0;
                        turn_n  = '0;
                        if (last_write && !dir[win] && (TURN > 0)) begin
                            state_n  = S_TURN;
                            uio_oe_n = 8'h00;
                        end else begin
                            state_n = S_OWN;
                            gnt_n   = onehot(win);
                        end
                    end
                end
                S_TURN: begin
                    uio_oe_n = 8'h00;
                    if (turn_cnt == TW'(TURN - 1)) begin
                        state_n = S_OWN;
                        gnt_n   = onehot(owner);
                    end else begin
                        turn_n = turn_cnt + 1'b1;
                    end
                end
                S_OWN: begin
                    if (req[owner]) begin
                        beat_n = beat + 1'b1;
                        if (bdir) begin
                            uio_out_n = wdata[{owner, 3'b000} +: 8];
                            uio_oe_n  = 8'hFF;
                        end else begin
                            uio_oe_n = 8'h00;
                            rdata_n  = uio_in;
                            rvalid_n = 1'b1;
                        end
                    end
                    if (!req[owner] || (beat_n == BW'(MAXBURST))) begin
                        state_n      = S_IDLE;
                        gnt_n        = '0;
                        ptr_n        = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                        last_write_n = bdir;
                        beat_n       = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gnt        <= '0;
            rdata      <= 8'h00;
            rvalid     <= 1'b0;
            busy       <= 1'b0;
            uio_out    <= 8'h00;
            uio_oe     <= 8'h00;
            ptr        <= '0;
            last_write <= 1'b0;
            beat       <= '0;
            owner      <= '0;
            bdir       <= 1'b0;
            turn_cnt   <= '0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            rdata      <= rdata_n;
            rvalid     <= rvalid_n;
            busy       <= busy_n;
            uio_out    <= uio_out_n;
            uio_oe     <= uio_oe_n;
            ptr        <= ptr_n;
            last_write <= last_write_n;
            beat       <= beat_n;
            owner      <= owner_n;
            bdir       <= bdir_n;
            turn_cnt   <= turn_n;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: directed bursts push expected grants/read data,
// a negedge monitor pops and compares as grants complete and rvalid pulses appear.
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, ena;
    logic [2:0]  req, dir, gnt;
    logic [23:0] wdata;
    logic [7:0]  rdata, uio_in, uio_out, uio_oe;
    logic        rvalid, busy;

    always #5 clk = ~clk;

    uio_bus_arbiter #(.NREQ(3), .TURN(1), .MAXBURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
        .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    typedef struct { logic [2:0] g; int len; } gexp_t;

    gexp_t      gq[$];
    logic [7:0] rq[$];
    int         total = 0;
    int         bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_g(input logic [2:0] g, input int len);
        gexp_t e;
        e.g   = g;
        e.len = len;
        gq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: completed grants, rvalid pulses, bus invariants
    logic [2:0] cur_g  = 3'b000;
    logic [2:0] prev_g = 3'b000;
    int         cur_len = 0;
    gexp_t      mon_e;
    logic [7:0] mon_r;

    always @(negedge clk) begin
        if (cur_g != 3'b000 && gnt !== cur_g) begin
            total++;
            if (gq.size() == 0) begin
                bad++;
                $display("FAIL grant_extra: got gnt %b len %0d expected none", cur_g, cur_len);
            end else begin
                mon_e = gq.pop_front();
                if (mon_e.g !== cur_g || mon_e.len != cur_len) begin
                    bad++;
                    $display("FAIL grant: got gnt %b len %0d expected gnt %b len %0d",
                             cur_g, cur_len, mon_e.g, mon_e.len);
                end
            end
            cur_g = 3'b000;
        end
        if (gnt != 3'b000 && cur_g == 3'b000) begin
            total++;
            if (prev_g !== 3'b000) begin
                bad++;
                $display("FAIL grant_gap: got prev gnt %b expected 000", prev_g);
            end
            cur_g   = gnt;
            cur_len = 0;
        end
        if (cur_g != 3'b000) cur_len++;
        prev_g = gnt;

        if (rvalid === 1'b1) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL rvalid_extra: got rdata %h expected no rvalid", rdata);
            end else begin
                mon_r = rq.pop_front();
                if (rdata !== mon_r) begin
                    bad++;
                    $display("FAIL rdata: got %h expected %h", rdata, mon_r);
                end
            end
        end

        total++;
        if ($countones(gnt) > 1 || (uio_oe !== 8'h00 && uio_oe !== 8'hFF)) begin
            bad++;
            $display("FAIL invariant: got gnt %b oe %h expected onehot0 and oe 00/FF", gnt, uio_oe);
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; req = 3'b111; dir = 3'b000; wdata = 24'h0; uio_in = 8'h00;

        // Reset with all requests asserted
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_gnt", {5'b0, gnt}, 8'h00);
            chk("rst_oe", uio_oe, 8'h00);
            chk("rst_out", uio_out, 8'h00);
            chk("rst_rvalid", {7'b0, rvalid}, 8'h00);
            chk("rst_busy", {7'b0, busy}, 8'h00);
        end
        req = 3'b000; rst_n = 1'b1;
        step();

        // Single write burst, two beats
        req = 3'b001; dir = 3'b001; wdata = 24'h0000A5;
        push_g(3'b001, 3);
        step(); chk("w_gnt", {5'b0, gnt}, 8'h01); chk("w_busy", {7'b0, busy}, 8'h01);
        step(); chk("w_out", uio_out, 8'hA5); chk("w_oe", uio_oe, 8'hFF);
        step(); req = 3'b000;
        step(); chk("w_gnt_off", {5'b0, gnt}, 8'h00); chk("w_keep_oe", uio_oe, 8'hFF);
        chk("w_idle", {7'b0, busy}, 8'h00);

        rst_n = 1'b0; step(); rst_n = 1'b1;

        // Round robin with MAXBURST-limited write bursts
        req = 3'b111; dir = 3'b111; wdata = 24'h332211;
        push_g(3'b001, 4); push_g(3'b010, 4); push_g(3'b100, 4); push_g(3'b001, 4);
        for (int s = 1; s <= 20; s++) begin
            step();
            if (s == 2)  chk("rr_out0", uio_out, 8'h11);
            if (s == 7)  chk("rr_out1", uio_out, 8'h22);
            if (s == 12) chk("rr_out2", uio_out, 8'h33);
        end
        req = 3'b000;

        // Write by req0, then read by req1 with turnaround
        dir = 3'b001; req = 3'b001; wdata = 24'h00005A;
        push_g(3'b001, 3);
        step();
        step(); chk("t_wout", uio_out, 8'h5A);
        step(); req = 3'b000;
        step();
        req = 3'b010; dir = 3'b000; uio_in = 8'h3C;
        push_g(3'b010, 3); rq.push_back(8'h3C); rq.push_back(8'hC3);
        step(); chk("t_turn_gnt", {5'b0, gnt}, 8'h00); chk("t_turn_oe", uio_oe, 8'h00);
        chk("t_turn_busy", {7'b0, busy}, 8'h01);
        step(); chk("t_gnt", {5'b0, gnt}, 8'h02);
        step(); chk("t_rvalid", {7'b0, rvalid}, 8'h01); chk("t_rdata", rdata, 8'h3C);
        uio_in = 8'hC3;
        step(); req = 3'b000;
        step(); chk("t_end", {5'b0, gnt}, 8'h00);

        // ena abort during beat 2 of req2 write
        req = 3'b100; dir = 3'b100; wdata = 24'h770000;
        push_g(3'b100, 2);
        step(); chk("e_gnt", {5'b0, gnt}, 8'h04);
        step(); chk("e_out", uio_out, 8'h77); chk("e_oe", uio_oe, 8'hFF);
        ena = 1'b0;
        step(); chk("e_gnt_off", {5'b0, gnt}, 8'h00); chk("e_oe_off", uio_oe, 8'h00);
        chk("e_busy", {7'b0, busy}, 8'h00);
        ena = 1'b1; req = 3'b101; dir = 3'b000; uio_in = 8'h44;
        push_g(3'b100, 2); rq.push_back(8'h44);
        step(); chk("e_rr_gnt", {5'b0, gnt}, 8'h04);
        step(); req = 3'b000;
        step(); chk("e_end", {5'b0, gnt}, 8'h00);

        // Reset during beat 3 of a req1 read, ptr previously advanced to 1
        req = 3'b001; dir = 3'b000; uio_in = 8'h01;
        push_g(3'b001, 2); rq.push_back(8'h01);
        step();
        step(); req = 3'b000;
        step();
        req = 3'b010; uio_in = 8'h10;
        push_g(3'b010, 3); rq.push_back(8'h10); rq.push_back(8'h20);
        step(); chk("r_gnt", {5'b0, gnt}, 8'h02);
        step(); uio_in = 8'h20;
        step(); rst_n = 1'b0; uio_in = 8'h30;
        step();
        chk("r_gnt_rst", {5'b0, gnt}, 8'h00); chk("r_rvalid_rst", {7'b0, rvalid}, 8'h00);
        chk("r_rdata_rst", rdata, 8'h00); chk("r_oe_rst", uio_oe, 8'h00);
        chk("r_out_rst", uio_out, 8'h00); chk("r_busy_rst", {7'b0, busy}, 8'h00);
        rst_n = 1'b1; req = 3'b011; uio_in = 8'h55;
        push_g(3'b001, 2); rq.push_back(8'h55);
        step(); chk("r_first_gnt", {5'b0, gnt}, 8'h01);
        step(); req = 3'b000;
        step(); chk("r_end", {5'b0, gnt}, 8'h00); chk("r_rdata", rdata, 8'h55);

        step(); step();
        chk("gq_empty", 8'(gq.size()), 8'h00);
        chk("rq_empty", 8'(rq.size()), 8'h00);
        chk("no_open_grant", {5'b0, cur_g}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
